// File: rtl/me_pkg.sv
// Shared motion-estimation constants and types used by the SAD accumulator slice.
package me_pkg;

  localparam int PIX_W     = 8;
  localparam int BLK_PIX   = 16;
  localparam int SAD_W     = 16;
  localparam int ROW_SAD_W = 12;
  localparam int ROW_W     = PIX_W * BLK_PIX;
  localparam int CNT_W     = 5;

  typedef struct packed {
    logic signed [PIX_W-1:0] x;
    logic signed [PIX_W-1:0] y;
  } mv_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sad_accumulator_if.sv
// Row-in / result-out bundle between the pixel fetcher, the SAD accumulator and the min-SAD comparator.
interface sad_accumulator_if;
  import me_pkg::*;

  logic [ROW_W-1:0]        cur_row;
  logic [ROW_W-1:0]        ref_row;
  logic signed [PIX_W-1:0] row_mv_x;
  logic signed [PIX_W-1:0] row_mv_y;
  logic                    row_valid;
  logic                    row_ready;
  logic                    flush;
  logic [SAD_W-1:0]        sad;
  logic signed [PIX_W-1:0] sad_mv_x;
  logic signed [PIX_W-1:0] sad_mv_y;
  logic                    sad_valid;
  logic                    sad_ready;

  modport master (
    output cur_row, ref_row, row_mv_x, row_mv_y, row_valid, flush, sad_ready,
    input  row_ready, sad, sad_mv_x, sad_mv_y, sad_valid
  );

  modport slave (
    input  cur_row, ref_row, row_mv_x, row_mv_y, row_valid, flush, sad_ready,
    output row_ready, sad, sad_mv_x, sad_mv_y, sad_valid
  );

endinterface

// File: rtl/sad_row.sv
// Combinational row SAD: 16 absolute pixel differences reduced by a balanced adder tree.
module sad_row
  import me_pkg::*;
(
  input  logic [ROW_W-1:0]     cur_row_i,
  input  logic [ROW_W-1:0]     ref_row_i,
  output logic [ROW_SAD_W-1:0] row_sad_o
);

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [PIX_W-1:0] diff [BLK_PIX];
  logic [PIX_W:0]   lvl1 [8];
  logic [PIX_W+1:0] lvl2 [4];
  logic [PIX_W+2:0] lvl3 [2];

  // Each tree level grows by one bit, so 16 x 255 lands exactly in 12 bits.
  always_comb begin
    for (int k = 0; k < BLK_PIX; k++) begin
      diff[k] = abs_diff(cur_row_i[k*PIX_W +: PIX_W], ref_row_i[k*PIX_W +: PIX_W]);
    end
    for (int i = 0; i < 8; i++) begin
      lvl1[i] = {1'b0, diff[2*i]} + {1'b0, diff[2*i+1]};
    end
    for (int i = 0; i < 4; i++) begin
      lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
    end
    row_sad_o = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};
  end

endmodule

// File: rtl/sad_accumulator.sv
// Accumulates per-row SADs over BLK_ROWS rows of one candidate MV and holds the block SAD
// until the min-SAD comparator takes it.
module sad_accumulator
  import me_pkg::*;
#(
  parameter int BLK_ROWS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sad_accumulator_if.slave   sad_if
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_ROWS - 1);
  localparam bit               ONE_ROW  = (BLK_ROWS == 1);

  state_e               state_q, state_d;
  logic [SAD_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     row_cnt_q, row_cnt_d;
  mv_t                  mv_q, mv_d;
  logic [SAD_W-1:0]     sad_q, sad_d;
  mv_t                  sad_mv_q, sad_mv_d;
  logic                 sad_valid_q, sad_valid_d;

  logic [ROW_SAD_W-1:0] row_sad;
  logic                 row_ready;
  logic                 start_blk;
  logic                 add_row;
  logic                 clr_blk;
  logic                 handoff;
  logic                 last_row;

  sad_row u_sad_row (
    .cur_row_i (sad_if.cur_row),
    .ref_row_i (sad_if.ref_row),
    .row_sad_o (row_sad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control strobes; flush wins over a row in IDLE/ACCUM but is ignored once a result is held.
  always_comb begin
    row_ready = 1'b0;
    start_blk = 1'b0;
    add_row   = 1'b0;
    clr_blk   = 1'b0;
    handoff   = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_IDLE: begin
          row_ready = 1'b1;
          clr_blk   = sad_if.flush;
          start_blk = sad_if.row_valid && !sad_if.flush;
        end
        ST_ACCUM: begin
          row_ready = 1'b1;
          clr_blk   = sad_if.flush;
          add_row   = sad_if.row_valid && !sad_if.flush;
        end
        ST_HOLD: begin
          row_ready = sad_if.sad_ready;
          handoff   = sad_if.sad_ready;
          start_blk = sad_if.row_valid && sad_if.sad_ready;
        end
        default: ;
      endcase
    end
  end

  assign last_row = (start_blk && ONE_ROW) || (add_row && (row_cnt_q == LAST_CNT));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_blk) state_d = last_row ? ST_HOLD : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (clr_blk)       state_d = ST_IDLE;
        else if (last_row) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (handoff) begin
          if (start_blk) state_d = last_row ? ST_HOLD : ST_ACCUM;
          else           state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    row_cnt_d   = row_cnt_q;
    mv_d        = mv_q;
    sad_d       = sad_q;
    sad_mv_d    = sad_mv_q;
    sad_valid_d = sad_valid_q;

    if (clr_blk || handoff) begin
      acc_d     = '0;
      row_cnt_d = '0;
    end
    if (handoff) sad_valid_d = 1'b0;

    if (start_blk) begin
      acc_d     = SAD_W'(row_sad);
      row_cnt_d = CNT_W'(1);
      mv_d.x    = sad_if.row_mv_x;
      mv_d.y    = sad_if.row_mv_y;
    end else if (add_row) begin
      acc_d     = acc_q + SAD_W'(row_sad);
      row_cnt_d = row_cnt_q + CNT_W'(1);
    end

    // The result register is loaded with the final sum on the edge of the last row.
    if (last_row) begin
      sad_d       = acc_d;
      sad_mv_d    = mv_d;
      sad_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      row_cnt_q   <= '0;
      mv_q        <= '0;
      sad_q       <= '1;
      sad_mv_q    <= '0;
      sad_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      row_cnt_q   <= row_cnt_d;
      mv_q        <= mv_d;
      sad_q       <= sad_d;
      sad_mv_q    <= sad_mv_d;
      sad_valid_q <= sad_valid_d;
    end
  end

  assign sad_if.row_ready = row_ready;
  assign sad_if.sad       = sad_q;
  assign sad_if.sad_mv_x  = sad_mv_q.x;
  assign sad_if.sad_mv_y  = sad_mv_q.y;
  assign sad_if.sad_valid = sad_valid_q;

endmodule

// File: tb/tb_sad_accumulator.sv
// Self-checking bench for sad_accumulator: directed scenarios plus randomized traffic against a
// block-level reference model.
module tb_sad_accumulator;

  localparam int BLK = 16;

  logic clk;
  logic rst_n;

  sad_accumulator_if bus ();

  sad_accumulator #(.BLK_ROWS(BLK)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sad_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int row_sad_ref(input logic [127:0] c, input logic [127:0] r);
    int s, a, b;
    s = 0;
    for (int k = 0; k < 16; k++) begin
      a = int'(c[8*k +: 8]);
      b = int'(r[8*k +: 8]);
      s += (a > b) ? (a - b) : (b - a);
    end
    return s;
  endfunction

  // Reference model: rows collected into a running sum, a finished block becomes a pending result.
  bit                 m_on = 1'b0;
  bit                 m_hold;
  bit                 m_take;
  int                 m_cnt;
  int                 m_sum;
  logic [15:0]        m_sad;
  logic signed [7:0]  m_mvx, m_mvy, m_bx, m_by;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on   = 1'b1;
      m_hold = 1'b0;
      m_cnt  = 0;
      m_sum  = 0;
      m_sad  = 16'hffff;
      m_bx   = '0;
      m_by   = '0;
      m_mvx  = '0;
      m_mvy  = '0;
    end else if (m_on) begin
      m_take = bus.row_valid && (!m_hold || bus.sad_ready);
      if (m_hold) begin
        if (bus.sad_ready) m_hold = 1'b0;
      end else if (bus.flush) begin
        m_take = 1'b0;
        m_cnt  = 0;
        m_sum  = 0;
      end
      if (m_take) begin
        if (m_cnt == 0) begin
          m_mvx = bus.row_mv_x;
          m_mvy = bus.row_mv_y;
          m_sum = 0;
        end
        m_sum += row_sad_ref(bus.cur_row, bus.ref_row);
        m_cnt++;
        if (m_cnt == BLK) begin
          m_hold = 1'b1;
          m_sad  = m_sum[15:0];
          m_bx   = m_mvx;
          m_by   = m_mvy;
          m_cnt  = 0;
          m_sum  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("row_ready", {31'b0, bus.row_ready},
            {31'b0, rst_n && (!m_hold || bus.sad_ready)});
      check("sad_valid", {31'b0, bus.sad_valid}, {31'b0, m_hold});
      check("sad", {16'b0, bus.sad}, {16'b0, m_sad});
      if (m_hold) begin
        check("sad_mv_x", {24'b0, bus.sad_mv_x}, {24'b0, m_bx});
        check("sad_mv_y", {24'b0, bus.sad_mv_y}, {24'b0, m_by});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [127:0] c, input logic [127:0] r,
                          input logic [7:0] mx, input logic [7:0] my);
    logic rdy;
    int   n;
    bus.cur_row   = c;
    bus.ref_row   = r;
    bus.row_mv_x  = mx;
    bus.row_mv_y  = my;
    bus.row_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = bus.row_ready;
      step();
      n++;
    end while (!rdy && n < 64);
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL row_accept_timeout: got no acceptance after %0d cycles", n);
    end
    bus.row_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [15:0] s,
                               input logic [7:0] mx, input logic [7:0] my);
    @(negedge clk);
    check({name, "_valid"}, {31'b0, bus.sad_valid}, 32'd1);
    check({name, "_sad"},   {16'b0, bus.sad}, {16'b0, s});
    check({name, "_mvx"},   {24'b0, bus.sad_mv_x}, {24'b0, mx});
    check({name, "_mvy"},   {24'b0, bus.sad_mv_y}, {24'b0, my});
    step();
  endtask

  logic [127:0] c_v, r_v;

  initial begin
    rst_n         = 1'b0;
    bus.cur_row   = '0;
    bus.ref_row   = '0;
    bus.row_mv_x  = '0;
    bus.row_mv_y  = '0;
    bus.row_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.sad_ready = 1'b1;
    repeat (3) step();

    @(negedge clk);
    check("rst_row_ready", {31'b0, bus.row_ready}, 32'd0);
    check("rst_sad",       {16'b0, bus.sad}, 32'h0000ffff);
    check("rst_sad_valid", {31'b0, bus.sad_valid}, 32'd0);
    check("rst_mv_x",      {24'b0, bus.sad_mv_x}, 32'd0);
    check("rst_mv_y",      {24'b0, bus.sad_mv_y}, 32'd0);
    step();
    rst_n = 1'b1;

    // 16 x 16 x |10-7| = 768, MV (3,-2), single-cycle pulse
    for (int i = 0; i < 16; i++) send_row({16{8'd10}}, {16{8'd7}}, 8'd3, 8'hfe);
    expect_result("s768", 16'd768, 8'd3, 8'hfe);
    @(negedge clk);
    check("s768_pulse_end", {31'b0, bus.sad_valid}, 32'd0);
    step();

    // Full-scale block: 16 x 16 x 255 = 65280
    for (int i = 0; i < 16; i++) send_row({16{8'hff}}, {16{8'h00}}, 8'h80, 8'h7f);
    expect_result("s_max", 16'd65280, 8'h80, 8'h7f);

    // Back-pressure: result held, then handoff and new first row on the same edge
    bus.sad_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c_v = {$urandom, $urandom, $urandom, $urandom};
      r_v = {$urandom, $urandom, $urandom, $urandom};
      send_row(c_v, r_v, 8'(i), 8'(i + 1));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_row_ready", {31'b0, bus.row_ready}, 32'd0);
      check("hold_valid",     {31'b0, bus.sad_valid}, 32'd1);
      step();
    end
    bus.sad_ready = 1'b1;
    send_row({16{8'd20}}, {16{8'd22}}, 8'd9, 8'd8);
    @(negedge clk);
    check("handoff_valid_clear", {31'b0, bus.sad_valid}, 32'd0);
    step();
    for (int i = 0; i < 15; i++) send_row({16{8'd20}}, {16{8'd22}}, 8'd1, 8'd1);
    expect_result("s512", 16'd512, 8'd9, 8'd8);

    // Flush after 7 rows drops them and the row offered alongside the flush
    for (int i = 0; i < 7; i++) send_row({16{8'hff}}, {16{8'h00}}, 8'd4, 8'd4);
    bus.flush     = 1'b1;
    bus.row_valid = 1'b1;
    bus.cur_row   = {16{8'hff}};
    bus.ref_row   = '0;
    step();
    bus.flush     = 1'b0;
    bus.row_valid = 1'b0;
    for (int i = 0; i < 16; i++) send_row({16{8'd5}}, {16{8'd1}}, 8'd6, 8'hfa);
    expect_result("s_flush", 16'd1024, 8'd6, 8'hfa);

    // Rows with a gap cycle between each
    for (int i = 0; i < 16; i++) begin
      send_row({16{8'd7}}, {16{8'd10}}, 8'hfb, 8'd7);
      if (i != 15) step();
    end
    expect_result("s_gaps", 16'd768, 8'hfb, 8'd7);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bus.cur_row   = {$urandom, $urandom, $urandom, $urandom};
      bus.ref_row   = {$urandom, $urandom, $urandom, $urandom};
      bus.row_mv_x  = 8'($urandom);
      bus.row_mv_y  = 8'($urandom);
      bus.row_valid = ($urandom_range(0, 9) < 7);
      bus.sad_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    bus.row_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.sad_ready = 1'b1;
    repeat (3) step();

    // Reset while holding a result discards it without a handoff
    bus.sad_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_row({16{8'd3}}, {16{8'd1}}, 8'd2, 8'd2);
    @(negedge clk);
    check("pre_rst_valid", {31'b0, bus.sad_valid}, 32'd1);
    step();
    rst_n         = 1'b0;
    bus.sad_ready = 1'b1;
    @(negedge clk);
    check("rst_hold_row_ready", {31'b0, bus.row_ready}, 32'd0);
    step();
    @(negedge clk);
    check("rst_hold_valid", {31'b0, bus.sad_valid}, 32'd0);
    check("rst_hold_sad",   {16'b0, bus.sad}, 32'h0000ffff);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sad_accumulator.md
SAD_ACCUMULATOR -- requirements
Module: sad_accumulator

Interface
REQ-001 The block SHALL have parameter BLK_ROWS, default 16, giving the rows per candidate block; legal values are 1..16.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port cur_row, input, 128 bits: 16 unsigned 8-bit current-MB pixels, pixel k at bits [8k+7:8k].
REQ-005 The block SHALL have port ref_row, input, 128 bits: 16 unsigned 8-bit search-window pixels, same packing.
REQ-006 The block SHALL have port row_mv_x and row_mv_y, input, 8 bits each, signed: candidate MV, sampled on the first row only.
REQ-007 The block SHALL have port row_valid, input, 1 bit: the row inputs are valid.
REQ-008 The block SHALL have port row_ready, output, 1 bit: the block accepts a row this cycle.
REQ-009 The block SHALL have port flush, input, 1 bit: discard the partial block.
REQ-010 The block SHALL have port sad, output, 16 bits: completed candidate SAD.
REQ-011 The block SHALL have port sad_mv_x and sad_mv_y, output, 8 bits each: MV tag of sad.
REQ-012 The block SHALL have port sad_valid, output, 1 bit: sad and its MV tag are valid.
REQ-013 The block SHALL have port sad_ready, input, 1 bit: downstream min-SAD comparator consumes the result.

Function
REQ-014 A row SHALL be accepted on a clock edge where row_valid and row_ready are both 1.
REQ-015 Per accepted row, the row SAD SHALL be the sum over k=0..15 of |cur_k - ref_k|, computed combinationally at 12 bits, max 4080.
REQ-016 The accumulator SHALL be 16 bits with no saturation; max 16*4080 = 65280 cannot overflow.
REQ-017 The FSM SHALL have the states IDLE, ACCUM and HOLD.
REQ-018 On acceptance in IDLE, the block SHALL load acc with the row SAD, load row_cnt with 1 and capture the MV; it SHALL go to ACCUM, or to HOLD if BLK_ROWS=1.
REQ-019 On acceptance in ACCUM, the block SHALL add the row SAD to acc and increment row_cnt; on acceptance of row BLK_ROWS it SHALL go to HOLD.
REQ-020 The block SHALL set sad_valid=1 in the cycle after the last row is accepted, giving a latency of 1 cycle; sad SHALL equal the final acc.
REQ-021 In HOLD, sad, sad_mv_x, sad_mv_y and sad_valid SHALL stay stable until sad_valid and sad_ready are both 1.
REQ-022 row_ready SHALL be 1 in IDLE and ACCUM.
REQ-023 In HOLD, row_ready SHALL equal sad_ready (combinational), so a result handoff and a new first row can occur in the same cycle.
REQ-024 On a HOLD handoff with a simultaneous row acceptance, the block SHALL start a new block as in IDLE; without a simultaneous row it SHALL go to IDLE.
REQ-025 In IDLE or ACCUM, flush=1 SHALL return the block to IDLE, clear acc and row_cnt, and ignore any row offered that cycle; flush takes priority.
REQ-026 In HOLD, flush SHALL be ignored; a completed result is never discarded.
REQ-027 The block SHALL not accumulate rows while row_valid=0; gaps between rows are allowed and row_cnt holds.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, acc=0, row_cnt=0, sad=16'hffff, sad_mv_x=0, sad_mv_y=0 and sad_valid=0.
REQ-029 A reset mid-block or in HOLD SHALL discard all partial and pending results.
REQ-030 row_ready SHALL be 0 while rst_n=0.

Structure
REQ-031 The shared package me_pkg SHALL hold the constants PIX_W=8, BLK_PIX=16 and SAD_W=16, and the type mv_t (signed 8-bit x, y).
REQ-032 The design SHALL have one sub-module, sad_row: 16 absolute differences plus an adder tree, purely combinational, with a 12-bit output.
REQ-033 The FSM, row_cnt, acc and output registers SHALL be implemented in sad_accumulator.

Verification
REQ-034 Scenario: 16 rows, all cur=8'd10 and ref=8'd7, MV (3,-2), sad_ready=1 -> sad=768, MV (3,-2), sad_valid for 1 cycle, 1 cycle after row 16.
REQ-035 Scenario: 16 rows, cur=8'hff and ref=8'h00 -> sad=65280 with no wrap.
REQ-036 Scenario: sad_ready=0 for 5 cycles after completion -> row_ready=0 and outputs stable; then raise sad_ready with row_valid=1 -> handoff and new first row accepted in the same cycle.
REQ-037 Scenario: 7 rows then flush=1 with row_valid=1 -> row ignored, state IDLE; the next 16 rows give a SAD of those 16 rows only.
REQ-038 Scenario: row_valid toggling 1/0 every cycle -> SAD identical to the back-to-back case, with completion at row 16.
REQ-039 Scenario: rst_n=0 in HOLD -> sad_valid=0 and sad=16'hffff on the next edge, and no handoff occurs.
